// File: rtl/userio_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : userio_sampler_pkg
// Description : Shared FIFO entry layout and count-width helper for the
//               USERIO input sampler.
// Revision    : 1.0 - initial release
// ============================================================================
package userio_sampler_pkg;

    // Entry layout: data in the LSBs, delta-timestamp directly above it.
    localparam int DATA_LSB = 0;

    function automatic int ts_lsb(input int data_width);
        return DATA_LSB + data_width;
    endfunction

    // Count must hold 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/userio_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : userio_event_fifo
// Description : First-word-fall-through event FIFO with separate count,
//               simultaneous read/write, write-drop and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module userio_event_fifo
    import userio_sampler_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_wr,
    input  logic [WIDTH-1:0]               i_wdata,
    input  logic                           i_rd,
    input  logic                           i_clear,
    output logic [WIDTH-1:0]               o_rdata,
    output logic                           o_empty,
    output logic [count_width(DEPTH)-1:0]  o_count,
    output logic                           o_overflow,
    output logic                           o_wr_accepted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             rd_ok, wr_ok;

    always_comb begin
        rd_ok      = i_rd && (count_q != '0) && !i_clear;
        // A pop in the same cycle frees the slot the write lands in.
        wr_ok      = i_wr && ((count_q != FULL_COUNT) || rd_ok) && !i_clear;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (i_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (wr_ok) begin
                mem_d[wr_ptr_q] = i_wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (i_wr && !wr_ok) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_empty       = (count_q == '0);
    assign o_rdata       = o_empty ? '0 : mem_q[rd_ptr_q];
    assign o_count       = count_q;
    assign o_overflow    = overflow_q;
    assign o_wr_accepted = wr_ok;

endmodule
`default_nettype wire

// File: rtl/userio_sampler.sv
`default_nettype none
// ============================================================================
// Module      : userio_sampler
// Description : Synchronizes asynchronous USERIO pins and logs every unmasked
//               level change as a {delta-timestamp, level} FIFO event.
//               Optional glitch filter: define USERIO_SAMPLER_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module userio_sampler
    import userio_sampler_pkg::*;
#(
    parameter int pWIDTH    = 8,
    parameter int pTS_WIDTH = 16,
    parameter int pDEPTH    = 16,
    parameter int pFILTER   = 3
) (
    input  logic                            usb_clk,
    input  logic                            reset_n,
    input  logic [pWIDTH-1:0]               userio_d_i,
    input  logic [pWIDTH-1:0]               I_userio_pwdriven,
    input  logic                            I_capture_en,
    input  logic                            I_clear,
    input  logic                            I_fifo_rd,
    output logic [pWIDTH-1:0]               O_userio_level,
    output logic [pTS_WIDTH+pWIDTH-1:0]     O_fifo_data,
    output logic                            O_fifo_empty,
    output logic [count_width(pDEPTH)-1:0]  O_fifo_count,
    output logic                            O_overflow
);
    localparam int ENTRY_W = pTS_WIDTH + pWIDTH;
    localparam logic [pTS_WIDTH-1:0] TS_MAX = '1;

    logic [pWIDTH-1:0]    sync1_q, sync1_d;
    logic [pWIDTH-1:0]    sync2_q, sync2_d;
    logic [pWIDTH-1:0]    prev_q, prev_d;
    logic [pWIDTH-1:0]    level;
    logic [pWIDTH-1:0]    chg;
    logic [pTS_WIDTH-1:0] ts_q, ts_d;
    logic [ENTRY_W-1:0]   entry;
    logic                 event_req;
    logic                 wr_accepted;

    always_comb begin
        sync1_d = userio_d_i;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ts_q    <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            ts_q    <= ts_d;
        end
    end

`ifdef USERIO_SAMPLER_GLITCH_FILTER_EN
    localparam int FCNT_W = $clog2(pFILTER) + 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(pFILTER - 1);

    logic [pWIDTH-1:0] filt_q, filt_d;
    logic [FCNT_W-1:0] fcnt_q [pWIDTH];
    logic [FCNT_W-1:0] fcnt_d [pWIDTH];

    // Accept a new value only after it has disagreed for pFILTER cycles running.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < pWIDTH; i++) begin
            fcnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FCNT_LAST) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge usb_clk) begin
        if (!reset_n) begin
            filt_q <= '0;
            for (int i = 0; i < pWIDTH; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync2_q;
`endif

    always_comb begin
        chg       = (level ^ prev_q) & ~I_userio_pwdriven;
        event_req = I_capture_en && (chg != '0) && !I_clear;

        entry = '0;
        entry[ts_lsb(pWIDTH) +: pTS_WIDTH] = ts_q;
        entry[DATA_LSB +: pWIDTH]          = level;

        // Delta restarts at 1 only when an entry actually lands in the FIFO.
        ts_d = ts_q;
        if (I_clear || !I_capture_en) begin
            ts_d = '0;
        end else if (wr_accepted) begin
            ts_d    = '0;
            ts_d[0] = 1'b1;
        end else if (ts_q != TS_MAX) begin
            ts_d = ts_q + 1'b1;
        end
    end

    userio_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (pDEPTH)
    ) u_fifo (
        .clk           (usb_clk),
        .rst_n         (reset_n),
        .i_wr          (event_req),
        .i_wdata       (entry),
        .i_rd          (I_fifo_rd),
        .i_clear       (I_clear),
        .o_rdata       (O_fifo_data),
        .o_empty       (O_fifo_empty),
        .o_count       (O_fifo_count),
        .o_overflow    (O_overflow),
        .o_wr_accepted (wr_accepted)
    );

    assign O_userio_level = level;

endmodule
`default_nettype wire
